gfx_wbm_readwrite64: RTL and testbench

//  Wishbone B3 classic master engine sitting below the 64-bit read/write arbiter.
//  - Consumes one arbitrated read_request_i/write_request_i at a time and runs one single-beat bus cycle.
//  - Returns ack_o and read data to the arbiter, which routes them back to the granted master.
//  - Only block in the GFX core that drives the external 64-bit memory bus.

---
 rtl/gfx_wbm_readwrite64.sv | 142 ++++++++++++++
 tb/tb_gfx_wbm_readwrite64.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/gfx_wbm_readwrite64.sv
// Wishbone B3 classic single-beat master for the 64-bit read/write arbiter.
// Optional bus watchdog enabled by defining GFX_WBM_TIMEOUT_EN.
module gfx_wbm_readwrite64 #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        read_request_i,
    input  logic        write_request_i,
    input  logic [28:0] addr_i,
    input  logic [7:0]  sel_i,
    input  logic [63:0] dat_i,
    output logic [63:0] dat_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        busy_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic [2:0]  wbm_cti_o,
    output logic [1:0]  wbm_bte_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [7:0]  wbm_sel_o,
    output logic [63:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic [63:0] wbm_dat_i
);

    typedef enum logic [1:0] {IDLE, BUS, ACK} state_t;

    state_t      state_q, state_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [28:0] adr_q, adr_d;
    logic [7:0]  sel_q, sel_d;
    logic [63:0] wdat_q, wdat_d;
    logic [63:0] rdat_q, rdat_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        timeout;

`ifdef GFX_WBM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
`ifdef GFX_WBM_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (read_request_i || write_request_i) begin
                    adr_d   = addr_i;
                    sel_d   = sel_i;
                    wdat_d  = dat_i;
                    we_d    = write_request_i;
                    cyc_d   = 1'b1;
                    state_d = BUS;
`ifdef GFX_WBM_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            BUS: begin
                if (wbm_ack_i || wbm_err_i || timeout) begin
                    cyc_d   = 1'b0;
                    ack_d   = 1'b1;
                    // error beats a simultaneous ack; watchdog only fires on a silent slave
                    err_d   = wbm_err_i | (~wbm_ack_i & timeout);
                    if (wbm_ack_i && !wbm_err_i && !we_q)
                        rdat_d = wbm_dat_i;
                    state_d = ACK;
                end
`ifdef GFX_WBM_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            sel_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef GFX_WBM_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
`ifdef GFX_WBM_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign dat_o     = rdat_q;
    assign ack_o     = ack_q;
    assign err_o     = err_q;
    assign busy_o    = (state_q != IDLE);
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_cti_o = 3'b000;
    assign wbm_bte_o = 2'b00;
    assign wbm_we_o  = we_q;
    assign wbm_adr_o = {adr_q, 3'b000};
    assign wbm_sel_o = sel_q;
    assign wbm_dat_o = wdat_q;

endmodule

// File: tb/tb_gfx_wbm_readwrite64.sv
// Directed + randomized bench for gfx_wbm_readwrite64; the slave is played inline.
module tb_gfx_wbm_readwrite64;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        read_request_i, write_request_i;
    logic [28:0] addr_i;
    logic [7:0]  sel_i;
    logic [63:0] dat_i, dat_o;
    logic        ack_o, err_o, busy_o;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic [31:0] wbm_adr_o;
    logic [7:0]  wbm_sel_o;
    logic [63:0] wbm_dat_o;
    logic        wbm_ack_i, wbm_err_i;
    logic [63:0] wbm_dat_i;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_dat = '0;  // reference copy of the last successfully read word

    always #5 clk_i = ~clk_i;

    gfx_wbm_readwrite64 #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .read_request_i(read_request_i), .write_request_i(write_request_i),
        .addr_i(addr_i), .sel_i(sel_i), .dat_i(dat_i),
        .dat_o(dat_o), .ack_o(ack_o), .err_o(err_o), .busy_o(busy_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_cti_o(wbm_cti_o),
        .wbm_bte_o(wbm_bte_o), .wbm_we_o(wbm_we_o), .wbm_adr_o(wbm_adr_o),
        .wbm_sel_o(wbm_sel_o), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_dat_i(wbm_dat_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction; waits = slave wait states before ack/err.
    task automatic xfer(input bit wr, input bit rd, input logic [28:0] a, input logic [7:0] s,
                        input logic [63:0] d, input int waits, input bit berr, input logic [63:0] rdat);
        int cyc_cnt;
        cyc_cnt = 0;
        @(negedge clk_i);
        write_request_i = wr; read_request_i = rd; addr_i = a; sel_i = s; dat_i = d;
        @(posedge clk_i); #1;
        chk("cyc_start", wbm_cyc_o, 1);
        chk("stb_start", wbm_stb_o, 1);
        chk("we", wbm_we_o, wr);
        chk("adr", wbm_adr_o, {a, 3'b000});
        chk("sel", wbm_sel_o, s);
        if (wr) chk("wdat", wbm_dat_o, d);
        chk("busy_bus", busy_o, 1);
        chk("cti_bte", {wbm_cti_o, wbm_bte_o}, 0);
        repeat (waits) begin
            @(negedge clk_i);
            if (wbm_cyc_o) cyc_cnt++;
        end
        @(negedge clk_i);
        if (wbm_cyc_o) cyc_cnt++;
        wbm_ack_i = !berr; wbm_err_i = berr; wbm_dat_i = rdat;
        @(posedge clk_i); #1;
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = {$urandom, $urandom};
        if (!berr && !wr) exp_dat = rdat;
        chk("cyc_end", wbm_cyc_o, 0);
        chk("ack_pulse", ack_o, 1);
        chk("err_pulse", err_o, berr);
        chk("dat_o", dat_o, exp_dat);
        chk("cyc_len", cyc_cnt, waits + 1);
        read_request_i = 1'b0; write_request_i = 1'b0;
        @(posedge clk_i); #1;
        chk("ack_clear", {ack_o, err_o}, 0);
        chk("idle", busy_o, 0);
        chk("dat_hold", dat_o, exp_dat);
    endtask

    initial begin
        read_request_i = 0; write_request_i = 0; addr_i = '0; sel_i = '0; dat_i = '0;
        wbm_ack_i = 0; wbm_err_i = 0; wbm_dat_i = '0;
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        chk("rst_outs", {wbm_cyc_o, wbm_stb_o, wbm_we_o, ack_o, err_o, busy_o}, 0);
        chk("rst_adr_sel", {wbm_adr_o, wbm_sel_o}, 0);
        chk("rst_wdat", wbm_dat_o, 0);
        chk("rst_dat_o", dat_o, 0);

        // directed cases
        xfer(0, 1, 29'h0000_0010, 8'hFF, 64'h0, 2, 0, 64'h1122_3344_5566_7788);
        xfer(1, 0, 29'h0000_0123, 8'h0F, 64'hDEAD_BEEF_0123_4567, 0, 0, 64'hAAAA_0000_BBBB_0000);
        xfer(1, 1, 29'h1FFF_FFFF, 8'h80, 64'h0F0F_0F0F_F0F0_F0F0, 1, 0, 64'hCAFE);
        xfer(0, 1, 29'h0000_0004, 8'h01, 64'h0, 1, 1, 64'h5555_6666_7777_8888);

        // stray ack/err in IDLE must not produce a completion
        @(negedge clk_i); wbm_ack_i = 1; wbm_err_i = 1;
        @(posedge clk_i); #1; wbm_ack_i = 0; wbm_err_i = 0;
        chk("idle_stray", {ack_o, err_o, wbm_cyc_o, busy_o}, 0);

        // reset while in BUS, then a late ack
        @(negedge clk_i); read_request_i = 1; addr_i = 29'h42;
        @(posedge clk_i); #1;
        chk("pre_rst_cyc", wbm_cyc_o, 1);
        @(negedge clk_i); rst_i = 1; read_request_i = 0;
        @(posedge clk_i); #1;
        chk("rst_mid_cyc", {wbm_cyc_o, ack_o, busy_o}, 0);
        exp_dat = '0;
        @(negedge clk_i); rst_i = 0; wbm_ack_i = 1; wbm_dat_i = 64'hBAD;
        @(posedge clk_i); #1; wbm_ack_i = 0;
        chk("late_ack", {ack_o, err_o, wbm_cyc_o}, 0);
        chk("late_ack_dat", dat_o, 0);
        xfer(0, 1, 29'h0000_0777, 8'h3C, 64'h0, 0, 0, 64'h0123_4567_89AB_CDEF);

        // randomized traffic against the reference
        for (int i = 0; i < 24; i++) begin
            bit wr, rd;
            wr = $urandom_range(0, 1);
            rd = wr ? bit'($urandom_range(0, 1)) : 1'b1;
            xfer(wr, rd, 29'($urandom), 8'($urandom), {$urandom, $urandom},
                 int'($urandom_range(0, 4)), ($urandom_range(0, 5) == 0),
                 {$urandom, $urandom});
        end

`ifdef GFX_WBM_TIMEOUT_EN
        begin
            int n;
            n = 0;
            @(negedge clk_i); read_request_i = 1; addr_i = 29'h99;
            @(posedge clk_i); #1;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk_i);
                if (!wbm_cyc_o) break;
                n++;
            end
            chk("to_len", n, 16);
            chk("to_ack_err", {ack_o, err_o}, 2'b11);
            chk("to_dat", dat_o, exp_dat);
            read_request_i = 0;
            @(posedge clk_i); #1;
            chk("to_idle", {ack_o, err_o, busy_o}, 0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
